// File: rtl/cpu_pipe_pkg.sv
// Shared fetch-pipeline definitions: PC width, the {pc, data} entry layout and
// the width helper for occupancy counters.
package cpu_pipe_pkg;

  localparam int unsigned PC_W_C = 32;

  typedef struct packed {
    logic [PC_W_C-1:0] pc;
    logic [0:0]        data;
  } if_entry_t;

  // Bits needed to hold an occupancy value from 0 to depth inclusive
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/if_pipe_buffer_mem.sv
// Entry storage for if_pipe_buffer: DEPTH x W register array, one synchronous
// write port and one asynchronous read port. Contents are deliberately not
// reset; validity is tracked by the owner's occupancy count.
module if_pipe_buffer_mem #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 33,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/if_pipe_buffer.sv
// Elastic fetch buffer between IF0 (PC generation) and IF1 (ICache return).
// Strict FIFO of {pc, data} with valid/ready on both sides and a flush that
// kills everything in flight. in_ready depends only on registered occupancy.
// Optional build macro IF_PIPE_BYPASS_EN: when empty, an incoming entry is
// presented on the output in the same cycle and is not stored if taken.
module if_pipe_buffer
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned PC_W   = PC_W_C,
  parameter int unsigned DATA_W = 1,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [PC_W-1:0]             in_pc,
  input  logic [DATA_W-1:0]           in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [PC_W-1:0]             out_pc,
  output logic [DATA_W-1:0]           out_data,
  output logic [cnt_width(DEPTH)-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = cnt_width(DEPTH);
  localparam int unsigned W     = PC_W + DATA_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [W-1:0]     head_entry;
  logic             head_vld;
  logic             byp_vld;
  logic             byp_take;
  logic             push;
  logic             pop;

  assign head_vld = (count_q != '0);
  assign in_ready = (count_q != FULL_CNT);
  assign count    = count_q;

`ifdef IF_PIPE_BYPASS_EN
  assign byp_vld  = (count_q == '0) & in_valid & ~flush;
`else
  assign byp_vld  = 1'b0;
`endif
  // A bypassed entry taken downstream in the same cycle never lands in storage
  assign byp_take = byp_vld & out_ready;

  assign out_valid = head_vld | byp_vld;
  assign push      = in_valid & in_ready & ~flush & ~byp_take;
  assign pop       = head_vld & out_ready & ~flush;

  if_pipe_buffer_mem #(
    .DEPTH (DEPTH),
    .W     (W),
    .AW    (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata ({in_pc, in_data}),
    .raddr (rd_ptr_q),
    .rdata (head_entry)
  );

  // Output mux: stored head first, then bypass path, otherwise zero
  always_comb begin
    out_pc   = '0;
    out_data = '0;
    if (head_vld) begin
      {out_pc, out_data} = head_entry;
    end else if (byp_vld) begin
      out_pc   = in_pc;
      out_data = in_data;
    end
  end

  // Next pointer/occupancy; flush wins over push and pop
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_if_pipe_buffer.sv
// Testbench for if_pipe_buffer (DEPTH=2). Follows IF_PIPE_BYPASS_EN if defined.
module tb_if_pipe_buffer;
  import cpu_pipe_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [0:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [0:0]  out_data;
  logic [1:0]  count;

  if_pipe_buffer #(.PC_W(32), .DATA_W(1), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_data  (out_data),
    .count     (count)
  );

  always #5 clk = ~clk;

  if_entry_t q[$];
  int n_vec = 0;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a plain queue; outputs derive from its size/head and the live inputs
  always @(negedge clk) begin
    int unsigned e_cnt;
    logic        e_vld;
    logic [31:0] e_pc;
    logic [0:0]  e_dat;
    e_cnt = q.size();
    e_vld = (e_cnt != 0);
    e_pc  = e_vld ? q[0].pc : 32'h0;
    e_dat = e_vld ? q[0].data : 1'b0;
`ifdef IF_PIPE_BYPASS_EN
    if (!e_vld && in_valid && !flush) begin
      e_vld = 1'b1;
      e_pc  = in_pc;
      e_dat = in_data;
    end
`endif
    n_vec++;
    check("count",     64'(count),     64'(e_cnt));
    check("in_ready",  64'(in_ready),  64'(e_cnt != DEPTH));
    check("out_valid", 64'(out_valid), 64'(e_vld));
    check("out_pc",    64'(out_pc),    64'(e_pc));
    check("out_data",  64'(out_data),  64'(e_dat));
  end

  // Advance the reference by one clock using the inputs held during that cycle
  task automatic model_edge();
    bit empty, do_pop, do_push;
    if (!rst_n || flush) begin
      q.delete();
    end else begin
      empty   = (q.size() == 0);
      do_pop  = !empty && out_ready;
      do_push = in_valid && (q.size() < DEPTH);
`ifdef IF_PIPE_BYPASS_EN
      if (empty && in_valid && out_ready) do_push = 1'b0;
`endif
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back('{pc: in_pc, data: in_data});
    end
  endtask

  // One cycle: clock edge, new inputs, then return just after the compare point
  task automatic step(input logic rst, input logic fl, input logic iv,
                      input logic [31:0] pc, input logic [0:0] d, input logic ordy);
    @(posedge clk);
    model_edge();
    #1;
    rst_n = rst; flush = fl; in_valid = iv; in_pc = pc; in_data = d; out_ready = ordy;
    if (!rst) q.delete();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_data = '0; out_ready = 1'b0;

    // Reset then idle
    repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_pc", 64'(out_pc), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Fill to full, third push refused
    step(1'b1, 1'b0, 1'b1, 32'h1C00_0000, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'h1C00_0004, 1'b0, 1'b0);
    check("fill_head", 64'(out_pc), 64'h1C00_0000);
    step(1'b1, 1'b0, 1'b1, 32'h1C00_0008, 1'b1, 1'b0);
    check("full_count", 64'(count), 64'd2);
    check("full_in_ready", 64'(in_ready), 64'd0);

    // Drain in order
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    check("drain0_pc", 64'(out_pc), 64'h1C00_0000);
    check("drain0_count", 64'(count), 64'd2);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    check("drain1_pc", 64'(out_pc), 64'h1C00_0004);
    check("drain1_count", 64'(count), 64'd1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("drained_valid", 64'(out_valid), 64'd0);
    check("drained_count", 64'(count), 64'd0);

    // Simultaneous push/pop at count 1, then 8 pairs through the wrap
    step(1'b1, 1'b0, 1'b1, 32'h0000_000C, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'h0000_0010, 1'b0, 1'b1);
    check("pp_head", 64'(out_pc), 64'h0C);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 1'b1, 32'h100 + 32'(4 * i), 1'(i), 1'b1);
      if (i == 0) begin
        check("pp_next_head", 64'(out_pc), 64'h10);
        check("pp_count", 64'(count), 64'd1);
      end
    end
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    check("wrap_last", 64'(out_pc), 64'h11C);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    // Flush mid-stream with a push in the same cycle
    step(1'b1, 1'b0, 1'b1, 32'h14, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'h18, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 32'h20, 1'b0, 1'b1);
    check("flush_cycle_count", 64'(count), 64'd2);
    check("flush_cycle_pc", 64'(out_pc), 64'h14);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("post_flush_count", 64'(count), 64'd0);
    check("post_flush_valid", 64'(out_valid), 64'd0);

    // Latency from empty
    step(1'b1, 1'b0, 1'b1, 32'h40, 1'b0, 1'b1);
`ifdef IF_PIPE_BYPASS_EN
    check("byp_valid", 64'(out_valid), 64'd1);
    check("byp_pc", 64'(out_pc), 64'h40);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    check("byp_count", 64'(count), 64'd0);
`else
    check("lat_valid0", 64'(out_valid), 64'd0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    check("lat_valid1", 64'(out_valid), 64'd1);
    check("lat_pc", 64'(out_pc), 64'h40);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("lat_count", 64'(count), 64'd0);
`endif

    // Random traffic with occasional flush and one mid-traffic reset
    for (int i = 0; i < 600; i++) begin
      logic rst;
      rst = !(i == 300 || i == 301);
      step(rst, ($urandom_range(15) == 0), rst & ($urandom_range(3) != 0),
           $urandom, 1'($urandom), ($urandom_range(2) != 0));
    end
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
